lock_water_level: RTL and testbench

Lock-chamber water-level controller that produces the 2-bit `water_status` consumed by the gate controller. It also drives the chamber fill and drain valves. The block accepts fill/drain requests, opens the matching valve only while both gates are closed, and tracks chamber level with a rate-divided counter. It reports low/high/filling/draining status back to the gate side.

---
 rtl/lock_water_level.sv | 108 ++++++++++
 tb/tb_lock_water_level.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_water_level.sv
// Lock-chamber water-level controller: fill/drain valves gated by the
// gate interlock, rate-divided level counter and status for the gate side.
module lock_water_level #(
  parameter int MAX_LEVEL = 15,
  parameter int RATE_DIV  = 4,
  parameter int LEVEL_W   = $clog2(MAX_LEVEL + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_req,
  input  logic               drain_req,
  input  logic [1:0]         gate_state,
  output logic [1:0]         water_status,
  output logic               fill_valve,
  output logic               drain_valve,
  output logic [LEVEL_W-1:0] level
);

  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LEVEL_W'(MAX_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);

  typedef enum logic [1:0] {
    LOW,
    FILLING,
    HIGH,
    DRAINING
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             gates_closed;
  logic             fill_only;
  logic             drain_only;
  logic             div_wrap;

  assign gates_closed = (gate_state == 2'b00);
  assign fill_only    = fill_req & ~drain_req;
  assign drain_only   = drain_req & ~fill_req;
  assign div_wrap     = (div == DIV_LAST);

  // Valves follow the gates combinationally so an opened gate cuts flow at once
  assign fill_valve  = (state == FILLING) & gates_closed;
  assign drain_valve = (state == DRAINING) & gates_closed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOW;
      level <= '0;
      div   <= '0;
    end else begin
      unique case (state)
        LOW: begin
          if (fill_only & gates_closed) begin
            state <= FILLING;
            div   <= '0;
          end
        end
        HIGH: begin
          if (drain_only & gates_closed) begin
            state <= DRAINING;
            div   <= '0;
          end
        end
        FILLING: begin
          if (drain_only) begin
            div   <= '0;
            state <= (level == '0) ? LOW : DRAINING;
          end else if (gates_closed) begin
            if (div_wrap) begin
              div   <= '0;
              level <= level + LVL_ONE;
              if (level == LVL_TOP) state <= HIGH;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        DRAINING: begin
          if (fill_only) begin
            div   <= '0;
            state <= (level == LVL_TOP + LVL_ONE) ? HIGH : FILLING;
          end else if (gates_closed) begin
            if (div_wrap) begin
              div   <= '0;
              level <= level - LVL_ONE;
              if (level == LVL_ONE) state <= LOW;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    water_status = 2'b10;
    unique case (state)
      LOW:      water_status = 2'b10;
      FILLING:  water_status = 2'b00;
      HIGH:     water_status = 2'b11;
      DRAINING: water_status = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_lock_water_level.sv
// Scoreboard bench for lock_water_level: directed stimulus queues
// cycle-tagged expectations, a negedge monitor pops and compares them.
module tb_lock_water_level;

  logic       clk;
  logic       reset;
  logic       fill_req;
  logic       drain_req;
  logic [1:0] gate_state;
  logic [1:0] water_status;
  logic       fill_valve;
  logic       drain_valve;
  logic [3:0] level;

  lock_water_level #(
    .MAX_LEVEL(15),
    .RATE_DIV (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fill_req    (fill_req),
    .drain_req   (drain_req),
    .gate_state  (gate_state),
    .water_status(water_status),
    .fill_valve  (fill_valve),
    .drain_valve (drain_valve),
    .level       (level)
  );

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       fv;
    logic       dv;
    logic [3:0] lvl;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [1:0] st,
                           input logic fv, input logic dv,
                           input int lvl, input string name);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.fv   = fv;
    e.dv   = dv;
    e.lvl  = 4'(lvl);
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step(1);
  endtask

  // Monitor: invariants every cycle, then any expectations due now
  always @(negedge clk) begin
    checks++;
    if ((fill_valve & drain_valve) ||
        ((gate_state != 2'b00) && (fill_valve | drain_valve)) ||
        (level > 4'd15)) begin
      errors++;
      $display("FAIL invariant cyc=%0d gate=%b fv=%b dv=%b lvl=%0d",
               cyc, gate_state, fill_valve, drain_valve, level);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation for cyc %0d at cyc %0d",
                 e.name, e.cyc, cyc);
      end else if (water_status !== e.st || fill_valve !== e.fv ||
                   drain_valve !== e.dv || level !== e.lvl) begin
        errors++;
        $display("FAIL %s cyc=%0d got st=%b fv=%b dv=%b lvl=%0d exp st=%b fv=%b dv=%b lvl=%0d",
                 e.name, cyc, water_status, fill_valve, drain_valve,
                 level, e.st, e.fv, e.dv, e.lvl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    fill_req   = 1'b0;
    drain_req  = 1'b0;
    gate_state = 2'b00;
    step(1);
    expect_at(cyc, 2'b10, 0, 0, 0, "reset_hold");
    step(2);
    reset = 1'b0;
    expect_at(cyc, 2'b10, 0, 0, 0, "reset_release");
    step(2);

    // Full fill from LOW
    t = cyc;
    expect_at(t + 1,  2'b00, 1, 0, 0,  "fill_open");
    expect_at(t + 4,  2'b00, 1, 0, 0,  "fill_lvl0");
    expect_at(t + 5,  2'b00, 1, 0, 1,  "fill_lvl1");
    expect_at(t + 60, 2'b00, 1, 0, 14, "fill_lvl14");
    expect_at(t + 61, 2'b11, 0, 0, 15, "fill_high");
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    run_to(t + 63);

    // Full drain from HIGH
    t = cyc;
    expect_at(t + 1,  2'b01, 0, 1, 15, "drain_open");
    expect_at(t + 5,  2'b01, 0, 1, 14, "drain_lvl14");
    expect_at(t + 9,  2'b01, 0, 1, 13, "drain_lvl13");
    expect_at(t + 60, 2'b01, 0, 1, 1,  "drain_lvl1");
    expect_at(t + 61, 2'b10, 0, 0, 0,  "drain_low");
    drain_req = 1'b1;
    step(1);
    drain_req = 1'b0;
    run_to(t + 63);

    // Interlock pause of 10 cycles at level 7
    t = cyc;
    expect_at(t + 29, 2'b00, 1, 0, 7,  "il_lvl7");
    expect_at(t + 30, 2'b00, 0, 0, 7,  "il_pause_start");
    expect_at(t + 39, 2'b00, 0, 0, 7,  "il_pause_end");
    expect_at(t + 40, 2'b00, 1, 0, 7,  "il_resume");
    expect_at(t + 42, 2'b00, 1, 0, 7,  "il_lvl7_late");
    expect_at(t + 43, 2'b00, 1, 0, 8,  "il_lvl8");
    expect_at(t + 70, 2'b00, 1, 0, 14, "il_lvl14");
    expect_at(t + 71, 2'b11, 0, 0, 15, "il_high");
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    run_to(t + 30);
    gate_state = 2'b01;
    run_to(t + 40);
    gate_state = 2'b00;
    run_to(t + 73);

    // Drain with a request ignored while the gate is open in HIGH
    t = cyc;
    expect_at(t + 1,  2'b11, 0, 0, 15, "high_gate_open_ignored");
    expect_at(t + 3,  2'b01, 0, 1, 15, "drain2_open");
    expect_at(t + 63, 2'b10, 0, 0, 0,  "drain2_low");
    gate_state = 2'b01;
    drain_req  = 1'b1;
    step(1);
    drain_req  = 1'b0;
    gate_state = 2'b00;
    step(1);
    drain_req = 1'b1;
    step(1);
    drain_req = 1'b0;
    run_to(t + 65);

    // fill_req in LOW with lower gate open is ignored and not latched
    t = cyc;
    expect_at(t + 1, 2'b10, 0, 0, 0, "low_gate_open_ignored");
    expect_at(t + 4, 2'b10, 0, 0, 0, "low_not_latched");
    gate_state = 2'b10;
    fill_req   = 1'b1;
    step(1);
    fill_req = 1'b0;
    step(1);
    gate_state = 2'b00;
    run_to(t + 6);

    // Reversal at level 3
    t = cyc;
    expect_at(t + 13, 2'b00, 1, 0, 3, "rev_lvl3");
    expect_at(t + 14, 2'b01, 0, 1, 3, "rev_draining");
    expect_at(t + 18, 2'b01, 0, 1, 2, "rev_lvl2");
    expect_at(t + 25, 2'b01, 0, 1, 1, "rev_lvl1");
    expect_at(t + 26, 2'b10, 0, 0, 0, "rev_low");
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    run_to(t + 13);
    drain_req = 1'b1;
    step(1);
    drain_req = 1'b0;
    run_to(t + 28);

    // Both requests in LOW: no change
    t = cyc;
    expect_at(t + 1, 2'b10, 0, 0, 0, "conflict_low");
    expect_at(t + 2, 2'b10, 0, 0, 0, "conflict_low2");
    fill_req  = 1'b1;
    drain_req = 1'b1;
    step(2);
    fill_req  = 1'b0;
    drain_req = 1'b0;
    run_to(t + 3);

    // Reverse to drain while filling at level 0 goes straight to LOW
    t = cyc;
    expect_at(t + 1, 2'b00, 1, 0, 0, "rev0_filling");
    expect_at(t + 2, 2'b10, 0, 0, 0, "rev0_low");
    fill_req = 1'b1;
    step(1);
    fill_req  = 1'b0;
    drain_req = 1'b1;
    step(1);
    drain_req = 1'b0;
    run_to(t + 4);

    // Asynchronous reset mid-fill at level 9, then restart
    t = cyc;
    expect_at(t + 37, 2'b00, 1, 0, 9, "ar_lvl9");
    expect_at(t + 38, 2'b10, 0, 0, 0, "ar_async");
    expect_at(t + 39, 2'b10, 0, 0, 0, "ar_held");
    expect_at(t + 40, 2'b10, 0, 0, 0, "ar_released");
    expect_at(t + 41, 2'b00, 1, 0, 0, "ar_refill");
    expect_at(t + 45, 2'b00, 1, 0, 1, "ar_refill_lvl1");
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    run_to(t + 38);
    reset = 1'b1;
    run_to(t + 40);
    reset    = 1'b0;
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    run_to(t + 47);

    step(2);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared (cyc %0d)", e.name, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
